// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: pays out quarters, dimes and nickels from a
// restockable inventory, one timed solenoid pulse per coin.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [5:0] req_amount,
    output logic       req_ready,
    input  logic       restock,
    input  logic [5:0] restock_n,
    input  logic [5:0] restock_d,
    input  logic [5:0] restock_q,
    output logic       eject_n,
    output logic       eject_d,
    output logic       eject_q,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [5:0] remaining,
    output logic [5:0] inv_n,
    output logic [5:0] inv_d,
    output logic [5:0] inv_q
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_PULSE  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_N    = 2'd1;
    localparam logic [1:0] C_D    = 2'd2;
    localparam logic [1:0] C_Q    = 2'd3;

    localparam int MAX_CNT = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT + 1) : 1;

    logic [2:0]    state_r;
    logic [1:0]    coin_r;
    logic [CW-1:0] cnt_r;
    logic [5:0]    rem_r;
    logic [5:0]    inv_n_r;
    logic [5:0]    inv_d_r;
    logic [5:0]    inv_q_r;
    logic          short_r;

    logic [1:0]    pick;
    logic          pick_short;
    logic [5:0]    pick_value;

    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[6] ? 6'd63 : s[5:0];
    endfunction

    // Greedy choice for the current SELECT cycle, largest coin first.
    always_comb begin
        pick       = C_NONE;
        pick_short = 1'b0;
        pick_value = 6'd0;
        if (rem_r >= 6'd25 && inv_q_r != 6'd0) begin
            pick       = C_Q;
            pick_value = 6'd25;
        end else if (rem_r >= 6'd10 && inv_d_r != 6'd0) begin
            pick       = C_D;
            pick_value = 6'd10;
        end else if (rem_r >= 6'd5 && inv_n_r != 6'd0) begin
            pick       = C_N;
            pick_value = 6'd5;
        end else if (rem_r >= 6'd5) begin
            pick_short = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            coin_r  <= C_NONE;
            cnt_r   <= '0;
            rem_r   <= 6'd0;
            inv_n_r <= 6'd0;
            inv_d_r <= 6'd0;
            inv_q_r <= 6'd0;
            short_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (restock) begin
                        inv_n_r <= sat_add(inv_n_r, restock_n);
                        inv_d_r <= sat_add(inv_d_r, restock_d);
                        inv_q_r <= sat_add(inv_q_r, restock_q);
                    end
                    if (req_valid) begin
                        rem_r   <= req_amount;
                        short_r <= 1'b0;
                        state_r <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (pick != C_NONE) begin
                        coin_r  <= pick;
                        rem_r   <= rem_r - pick_value;
                        cnt_r   <= '0;
                        state_r <= S_PULSE;
                        case (pick)
                            C_Q:     inv_q_r <= inv_q_r - 6'd1;
                            C_D:     inv_d_r <= inv_d_r - 6'd1;
                            default: inv_n_r <= inv_n_r - 6'd1;
                        endcase
                    end else begin
                        short_r <= pick_short;
                        state_r <= S_FINISH;
                    end
                end
                S_PULSE: begin
                    if (cnt_r == CW'(PULSE_CYCLES - 1)) begin
                        cnt_r   <= '0;
                        state_r <= (GAP_CYCLES > 0) ? S_GAP : S_SELECT;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_r == CW'(GAP_CYCLES - 1)) begin
                        cnt_r   <= '0;
                        state_r <= S_SELECT;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                S_FINISH: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so a reset edge drops them immediately.
    assign req_ready = (state_r == S_IDLE);
    assign busy      = (state_r != S_IDLE);
    assign eject_q   = (state_r == S_PULSE) && (coin_r == C_Q);
    assign eject_d   = (state_r == S_PULSE) && (coin_r == C_D);
    assign eject_n   = (state_r == S_PULSE) && (coin_r == C_N);
    assign done      = (state_r == S_FINISH);
    assign short     = (state_r == S_FINISH) && short_r;
    assign remaining = rem_r;
    assign inv_n     = inv_n_r;
    assign inv_d     = inv_d_r;
    assign inv_q     = inv_q_r;

endmodule
